// File: rtl/raster_scan_sequencer.sv
// raster_scan_sequencer
//   Raster coordinate source for the ray-march pixel pipeline. It emits beats of
//   LANES adjacent pixels in raster order over a frame size that is configured at
//   run time. Each beat carries start-of-frame, end-of-line and end-of-frame flags.
//   Credit-based flow control limits the number of beats in flight downstream.
//   The block supports start/stop, single-shot or continuous operation and keeps a
//   count of completed frames.
//
// Ports
//   clk, rst       pipeline clock, synchronous active-high reset
//   cfg_width      frame width in pixels (sampled at start and at each frame boundary)
//   cfg_height     frame height in lines (sampled with cfg_width)
//   cfg_single     1 = one frame per start, 0 = continuous
//   start, stop    1-cycle control requests
//   coord_valid/coord_ready  beat handshake
//   coord_x/y      lane-0 x and line y of the current beat
//   coord_sof/eol/eof        frame/line markers of the current beat
//   credit_ret     one beat retired at the pipeline output
//   busy           sequencer not idle
//   in_flight      beats issued but not yet returned
//   frame_count    completed frames since reset (wraps)
//   cfg_err        1-cycle pulse: config rejected
//   credit_err     sticky: credit returned while nothing was in flight
module raster_scan_sequencer #(
  parameter  int X_WIDTH     = 10,
  parameter  int Y_WIDTH     = 9,
  parameter  int LANES       = 1,
  parameter  int MAX_CREDITS = 16,
  localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [X_WIDTH-1:0] cfg_width,
  input  logic [Y_WIDTH-1:0] cfg_height,
  input  logic               cfg_single,
  input  logic               start,
  input  logic               stop,
  output logic               coord_valid,
  input  logic               coord_ready,
  output logic [X_WIDTH-1:0] coord_x,
  output logic [Y_WIDTH-1:0] coord_y,
  output logic               coord_sof,
  output logic               coord_eol,
  output logic               coord_eof,
  input  logic               credit_ret,
  output logic               busy,
  output logic [CW-1:0]      in_flight,
  output logic [15:0]        frame_count,
  output logic               cfg_err,
  output logic               credit_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [X_WIDTH-1:0] r_x;
  logic [Y_WIDTH-1:0] r_y;
  logic [X_WIDTH-1:0] r_width;
  logic [Y_WIDTH-1:0] r_height;
  logic               r_single;
  logic               r_stop_pend;
  logic [CW-1:0]      r_in_flight;
  logic [15:0]        r_frame_count;
  logic               r_cfg_err;
  logic               r_credit_err;

  logic [X_WIDTH-1:0] w_x_nxt;
  logic [Y_WIDTH-1:0] w_y_nxt;
  logic [X_WIDTH-1:0] w_width_nxt;
  logic [Y_WIDTH-1:0] w_height_nxt;
  logic               w_single_nxt;
  logic               w_stop_pend_nxt;
  logic [CW-1:0]      w_in_flight_nxt;
  logic [15:0]        w_frame_count_nxt;
  logic               w_cfg_err_nxt;
  logic               w_credit_err_nxt;

  logic               w_cfg_ok;
  logic               w_valid;
  logic               w_accept;
  logic               w_ret;
  logic               w_eol;
  logic               w_eof;
  logic               w_sof;

  // Incoming configuration check, applied whenever a frame is about to begin.
  assign w_cfg_ok = (cfg_width != '0) && (cfg_height != '0) &&
                    ((cfg_width % X_WIDTH'(LANES)) == '0);

  // Valid depends only on registered state and in_flight. in_flight can rise
  // only through an accept, so a pending beat is never withdrawn.
  assign w_valid  = (r_state == S_RUN) && (r_in_flight < CW'(MAX_CREDITS));
  assign w_accept = w_valid && coord_ready;
  assign w_ret    = credit_ret && (r_in_flight != '0);

  // Flags are computed from the latched geometry. They are held low whenever no
  // beat is presented, so idle and reset outputs read as zero.
  assign w_eol = (r_x == (r_width - X_WIDTH'(LANES)));
  assign w_eof = w_eol && (r_y == (r_height - Y_WIDTH'(1)));
  assign w_sof = (r_x == '0) && (r_y == '0);

  always_comb begin
    w_in_flight_nxt = r_in_flight;
    if (w_accept && !w_ret) begin
      w_in_flight_nxt = r_in_flight + CW'(1);
    end else if (!w_accept && w_ret) begin
      w_in_flight_nxt = r_in_flight - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_width_nxt       = r_width;
    w_height_nxt      = r_height;
    w_single_nxt      = r_single;
    w_stop_pend_nxt   = r_stop_pend;
    w_frame_count_nxt = r_frame_count;
    w_cfg_err_nxt     = 1'b0;
    w_credit_err_nxt  = r_credit_err || (credit_ret && (r_in_flight == '0));

    unique case (r_state)
      S_IDLE: begin
        // A stop arriving with start is dropped: stop_pend is cleared here.
        if (start) begin
          if (w_cfg_ok) begin
            w_state_nxt     = S_RUN;
            w_width_nxt     = cfg_width;
            w_height_nxt    = cfg_height;
            w_single_nxt    = cfg_single;
            w_x_nxt         = '0;
            w_y_nxt         = '0;
            w_stop_pend_nxt = 1'b0;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (stop) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (w_accept) begin
          if (w_eol) begin
            w_x_nxt = '0;
            if (w_eof) begin
              w_y_nxt           = '0;
              w_frame_count_nxt = r_frame_count + 16'd1;
              // A stop seen on the eof beat itself still ends the run.
              if (r_single || r_stop_pend || stop) begin
                w_state_nxt     = S_DRAIN;
                w_stop_pend_nxt = 1'b0;
              end else if (w_cfg_ok) begin
                // Back-to-back frame: relatch geometry, no idle cycle.
                w_width_nxt  = cfg_width;
                w_height_nxt = cfg_height;
                w_single_nxt = cfg_single;
              end else begin
                w_state_nxt   = S_DRAIN;
                w_cfg_err_nxt = 1'b1;
              end
            end else begin
              w_y_nxt = r_y + Y_WIDTH'(1);
            end
          end else begin
            w_x_nxt = r_x + X_WIDTH'(LANES);
          end
        end
      end

      S_DRAIN: begin
        // Leave as soon as the counter is about to hit zero, including a
        // credit returning in this very cycle.
        if (w_in_flight_nxt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_single      <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_in_flight   <= '0;
      r_frame_count <= '0;
      r_cfg_err     <= 1'b0;
      r_credit_err  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_width       <= w_width_nxt;
      r_height      <= w_height_nxt;
      r_single      <= w_single_nxt;
      r_stop_pend   <= w_stop_pend_nxt;
      r_in_flight   <= w_in_flight_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_cfg_err     <= w_cfg_err_nxt;
      r_credit_err  <= w_credit_err_nxt;
    end
  end

  assign coord_valid = w_valid;
  assign coord_x     = r_x;
  assign coord_y     = r_y;
  assign coord_sof   = w_valid && w_sof;
  assign coord_eol   = w_valid && w_eol;
  assign coord_eof   = w_valid && w_eof;
  assign busy        = (r_state != S_IDLE);
  assign in_flight   = r_in_flight;
  assign frame_count = r_frame_count;
  assign cfg_err     = r_cfg_err;
  assign credit_err  = r_credit_err;

endmodule

// File: tb/tb_raster_scan_sequencer.sv
// Scoreboard bench for raster_scan_sequencer. Instance 0 runs with LANES=1 and
// MAX_CREDITS=4, instance 1 with LANES=4 and MAX_CREDITS=16.
module tb_raster_scan_sequencer;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][9:0]  cfg_w;
  logic [1:0][8:0]  cfg_h;
  logic [1:0]       single, start, stop, ready, cr, cr_man, auto_cr;
  logic [1:0]       valid, sof, eol, eof, busy, cerr, crerr;
  logic [1:0][9:0]  cx;
  logic [1:0][8:0]  cy;
  logic [1:0][15:0] fc;
  logic [2:0]       inf_a;
  logic [4:0]       inf_b;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t qa[$];
  beat_t qb[$];

  always #5 clk = ~clk;

  raster_scan_sequencer #(.X_WIDTH(10), .Y_WIDTH(9), .LANES(1), .MAX_CREDITS(4)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_width(cfg_w[0]), .cfg_height(cfg_h[0]),
    .cfg_single(single[0]), .start(start[0]), .stop(stop[0]),
    .coord_valid(valid[0]), .coord_ready(ready[0]), .coord_x(cx[0]), .coord_y(cy[0]),
    .coord_sof(sof[0]), .coord_eol(eol[0]), .coord_eof(eof[0]), .credit_ret(cr[0]),
    .busy(busy[0]), .in_flight(inf_a), .frame_count(fc[0]), .cfg_err(cerr[0]),
    .credit_err(crerr[0]));

  raster_scan_sequencer #(.X_WIDTH(10), .Y_WIDTH(9), .LANES(4), .MAX_CREDITS(16)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_width(cfg_w[1]), .cfg_height(cfg_h[1]),
    .cfg_single(single[1]), .start(start[1]), .stop(stop[1]),
    .coord_valid(valid[1]), .coord_ready(ready[1]), .coord_x(cx[1]), .coord_y(cy[1]),
    .coord_sof(sof[1]), .coord_eol(eol[1]), .coord_eof(eof[1]), .credit_ret(cr[1]),
    .busy(busy[1]), .in_flight(inf_b), .frame_count(fc[1]), .cfg_err(cerr[1]),
    .credit_err(crerr[1]));

  function automatic int qsize(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic beat_t qpop(input int d);
    if (d == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  task automatic push(input int d, input int x, input int y, input bit s, input bit l, input bit f);
    beat_t b;
    b.x = x[9:0];
    b.y = y[8:0];
    b.sof = s;
    b.eol = l;
    b.eof = f;
    if (d == 0) qa.push_back(b);
    else qb.push_back(b);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  // One-cycle credit as seen by the DUT; takes two bench cycles.
  task automatic credit_pulse(input int d);
    cr_man[d] = 1'b1;
    tick(1);
    cr_man[d] = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int d, input int budget, input string name);
    for (int i = 0; i < budget && busy[d]; i++) tick(1);
    check(name, busy[d], 0);
  endtask

  // Credit return: manual, or each accept echoed back two cycles later.
  initial begin
    logic [1:0][2:0] sh;
    sh = '0;
    cr = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) sh[d] = '0;
        else sh[d] = {sh[d][1:0], valid[d] & ready[d]};
        cr[d] = auto_cr[d] ? sh[d][2] : cr_man[d];
      end
    end
  end

  // Monitor: pops the scoreboard on each accept and checks that a stalled
  // beat stays put until accepted.
  initial begin
    beat_t      cur, e;
    beat_t      held [2];
    logic [1:0] hold;
    hold = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cur.x = cx[d];
        cur.y = cy[d];
        cur.sof = sof[d];
        cur.eol = eol[d];
        cur.eof = eof[d];
        if (!rst && hold[d]) begin
          n_cmp++;
          if (!valid[d] || cur !== held[d]) begin
            n_err++;
            $display("FAIL hold%0d: got valid=%0b beat=%h expected valid=1 beat=%h",
                     d, valid[d], cur, held[d]);
          end
        end
        if (!rst && valid[d] && ready[d]) begin
          n_cmp++;
          if (qsize(d) == 0) begin
            n_err++;
            $display("FAIL beat%0d: got unexpected beat %h expected none", d, cur);
          end else begin
            e = qpop(d);
            if (cur !== e) begin
              n_err++;
              $display("FAIL beat%0d: got %h expected %h", d, cur, e);
            end
          end
        end
        hold[d] = !rst && valid[d] && !ready[d];
        held[d] = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_w = '0; cfg_h = '0; single = '0; start = '0; stop = '0;
    ready = '0; cr_man = '0; auto_cr = '0;
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_inf_a", inf_a, 0);
    check("rst_flags_a", {sof[0], eol[0], eof[0]}, 0);
    check("rst_fc_a", fc[0], 0);
    rst = 1'b0;
    tick(1);

    // 1: LANES=1, 4x2 single shot, credits echoed back
    auto_cr[0] = 1'b1; ready[0] = 1'b1;
    cfg_w[0] = 10'd4; cfg_h[0] = 9'd2; single[0] = 1'b1;
    push(0, 0, 0, 1, 0, 0); push(0, 1, 0, 0, 0, 0); push(0, 2, 0, 0, 0, 0); push(0, 3, 0, 0, 1, 0);
    push(0, 0, 1, 0, 0, 0); push(0, 1, 1, 0, 0, 0); push(0, 2, 1, 0, 0, 0); push(0, 3, 1, 0, 1, 1);
    pulse_start(0);
    check("t1_first_valid", valid[0], 1);
    check("t1_busy", busy[0], 1);
    wait_idle(0, 100, "t1_idle");
    check("t1_fc", fc[0], 1);
    check("t1_inf", inf_a, 0);
    check("t1_q", qsize(0), 0);

    // 2: credit limit of 4 with no returns
    auto_cr[0] = 1'b0;
    cfg_w[0] = 10'd6; cfg_h[0] = 9'd1;
    push(0, 0, 0, 1, 0, 0); push(0, 1, 0, 0, 0, 0); push(0, 2, 0, 0, 0, 0);
    push(0, 3, 0, 0, 0, 0); push(0, 4, 0, 0, 0, 0); push(0, 5, 0, 0, 1, 1);
    pulse_start(0);
    tick(8);
    check("t2_inf_full", inf_a, 4);
    check("t2_valid_low", valid[0], 0);
    check("t2_q_left", qsize(0), 2);
    credit_pulse(0);
    tick(2);
    check("t2_inf_refill", inf_a, 4);
    check("t2_q_one_more", qsize(0), 1);

    // 3: stalled beat held while credits drain
    ready[0] = 1'b0;
    credit_pulse(0); credit_pulse(0); credit_pulse(0); credit_pulse(0);
    check("t3_inf", inf_a, 0);
    check("t3_valid", valid[0], 1);
    check("t3_x", cx[0], 5);
    check("t3_flags", {sof[0], eol[0], eof[0]}, 3'b011);
    ready[0] = 1'b1;
    tick(2);
    check("t3_drain_busy", busy[0], 1);
    check("t3_drain_inf", inf_a, 1);
    check("t3_fc", fc[0], 2);
    credit_pulse(0);
    check("t3_idle", busy[0], 0);
    check("t3_crerr", crerr[0], 0);

    // 4: LANES=4 continuous 8x2, stop mid frame 1
    auto_cr[1] = 1'b1; ready[1] = 1'b1;
    cfg_w[1] = 10'd8; cfg_h[1] = 9'd2; single[1] = 1'b0;
    push(1, 0, 0, 1, 0, 0); push(1, 4, 0, 0, 1, 0);
    push(1, 0, 1, 0, 0, 0); push(1, 4, 1, 0, 1, 1);
    pulse_start(1);
    stop[1] = 1'b1;
    tick(1);
    stop[1] = 1'b0;
    wait_idle(1, 100, "t4_idle");
    tick(3);
    check("t4_fc", fc[1], 1);
    check("t4_q", qsize(1), 0);
    check("t4_inf", inf_b, 0);

    // 5: invalid configs and stray credit
    auto_cr[1] = 1'b0;
    cfg_w[1] = 10'd6; cfg_h[1] = 9'd2; single[1] = 1'b1;
    pulse_start(1);
    check("t5_cerr_w", cerr[1], 1);
    check("t5_busy_w", busy[1], 0);
    tick(1);
    check("t5_cerr_clr", cerr[1], 0);
    cfg_w[1] = 10'd8; cfg_h[1] = 9'd0;
    pulse_start(1);
    check("t5_cerr_h", cerr[1], 1);
    check("t5_busy_h", busy[1], 0);
    credit_pulse(1);
    check("t5_crerr", crerr[1], 1);
    check("t5_inf", inf_b, 0);

    // 6: reset mid frame with three beats in flight
    ready[0] = 1'b1;
    cfg_w[0] = 10'd8; cfg_h[0] = 9'd1; single[0] = 1'b1;
    push(0, 0, 0, 1, 0, 0); push(0, 1, 0, 0, 0, 0); push(0, 2, 0, 0, 0, 0);
    pulse_start(0);
    tick(3);
    ready[0] = 1'b0;
    check("t6_inf_pre", inf_a, 3);
    rst = 1'b1;
    tick(1);
    check("t6_valid", valid[0], 0);
    check("t6_xy", {cx[0], cy[0]}, 0);
    check("t6_flags", {sof[0], eol[0], eof[0]}, 0);
    check("t6_busy", busy[0], 0);
    check("t6_inf", inf_a, 0);
    check("t6_fc", fc[0], 0);
    check("t6_errs", {cerr, crerr}, 0);
    rst = 1'b0;
    auto_cr[0] = 1'b1; ready[0] = 1'b1;
    cfg_w[0] = 10'd2; cfg_h[0] = 9'd1;
    push(0, 0, 0, 1, 0, 0); push(0, 1, 0, 0, 1, 1);
    tick(1);
    pulse_start(0);
    check("t6_resume_sof", {valid[0], sof[0], cx[0]}, {1'b1, 1'b1, 10'd0});
    wait_idle(0, 100, "t6_idle");
    check("t6_fc_after", fc[0], 1);
    check("end_qa", qsize(0), 0);
    check("end_qb", qsize(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
